// File: rtl/count_capture_if.sv
// Bundle between a ripple-counter source and the count_capture stage:
// the raw bus and enable in, the cleaned count and status flags out.
interface count_capture_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  cnt_in;
  logic              en;
  logic [WIDTH-1:0]  cnt_out;
  logic              cnt_valid;
  logic              wrap;
  logic              skip_err;
  logic [WRAP_W-1:0] wrap_count;
  logic              locked;

  modport master (
    output cnt_in, en,
    input  cnt_out, cnt_valid, wrap, skip_err, wrap_count, locked
  );

  modport slave (
    input  cnt_in, en,
    output cnt_out, cnt_valid, wrap, skip_err, wrap_count, locked
  );
endinterface

// File: rtl/count_capture.sv
// Captures an asynchronous ripple-counter bus: two-flop synchronizer, stability
// hold counter, then an accept FSM that reports new values, wraps and skips.
module count_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  count_capture_if.slave  bus
);

  localparam int H_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [H_W-1:0] H_MAX = H_W'(STABLE_CYCLES);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  logic [WIDTH-1:0]  s1_q, s1_d;
  logic [WIDTH-1:0]  s2_q, s2_d;
  logic [H_W-1:0]    h_q, h_d;
  logic [WIDTH-1:0]  cnt_out_q, cnt_out_d;
  logic              cnt_valid_q, cnt_valid_d;
  logic              wrap_q, wrap_d;
  logic              skip_err_q, skip_err_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              locked_q, locked_d;
  state_t            state_q, state_d;

  logic              accept;
  logic [WIDTH-1:0]  next_exp;

  // Saturating increment: the wrap tally sticks at all-ones instead of rolling over.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  function automatic logic [H_W-1:0] hold_inc(input logic [H_W-1:0] v);
    return (v >= H_MAX) ? H_MAX : v + H_W'(1);
  endfunction

  always_comb begin
    s1_d = bus.cnt_in;
    s2_d = s1_q;

    if (!bus.en)           h_d = '0;
    else if (s1_q == s2_q) h_d = hold_inc(h_q);
    else                   h_d = '0;

    // A value already reported is never re-reported once tracking.
    accept   = bus.en && (h_q == H_MAX) && ((state_q == INIT) || (s2_q != cnt_out_q));
    next_exp = cnt_out_q + WIDTH'(1);

    cnt_out_d    = cnt_out_q;
    cnt_valid_d  = 1'b0;
    wrap_d       = 1'b0;
    skip_err_d   = 1'b0;
    wrap_count_d = wrap_count_q;
    locked_d     = locked_q;
    state_d      = state_q;

    if (accept) begin
      cnt_out_d   = s2_q;
      cnt_valid_d = 1'b1;
      if (state_q == INIT) begin
        locked_d = 1'b1;
        state_d  = TRACK;
      end else if (s2_q == next_exp) begin
        if (&cnt_out_q) begin
          wrap_d       = 1'b1;
          wrap_count_d = sat_inc(wrap_count_q);
        end
      end else begin
        skip_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      h_q          <= '0;
      cnt_out_q    <= '0;
      cnt_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
      skip_err_q   <= 1'b0;
      wrap_count_q <= '0;
      locked_q     <= 1'b0;
      state_q      <= INIT;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      h_q          <= h_d;
      cnt_out_q    <= cnt_out_d;
      cnt_valid_q  <= cnt_valid_d;
      wrap_q       <= wrap_d;
      skip_err_q   <= skip_err_d;
      wrap_count_q <= wrap_count_d;
      locked_q     <= locked_d;
      state_q      <= state_d;
    end
  end

  assign bus.cnt_out    = cnt_out_q;
  assign bus.cnt_valid  = cnt_valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.skip_err   = skip_err_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: a default instance plus a WRAP_W=2
// instance fed identical stimulus to exercise tally saturation.
module tb_count_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_capture_if #(.WIDTH(4), .WRAP_W(8)) ifa ();
  count_capture_if #(.WIDTH(4), .WRAP_W(2)) ifb ();

  count_capture #(.WIDTH(4), .STABLE_CYCLES(2), .WRAP_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  count_capture #(.WIDTH(4), .STABLE_CYCLES(2), .WRAP_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  // Pulse tallies, counted as high cycles so a stretched pulse shows up too.
  int vld_a = 0, wrp_a = 0, skp_a = 0, wrp_b = 0, wrap_at_a = 0;
  always @(negedge clk) begin
    if (ifa.cnt_valid) vld_a = vld_a + 1;
    if (ifa.wrap) begin
      wrp_a     = wrp_a + 1;
      wrap_at_a = vld_a;
    end
    if (ifa.skip_err) skp_a = skp_a + 1;
    if (ifb.wrap)     wrp_b = wrp_b + 1;
  end

  task automatic drive(input logic [3:0] v);
    ifa.cnt_in = v;
    ifb.cnt_in = v;
  endtask

  task automatic set_en(input logic e);
    ifa.en = e;
    ifb.en = e;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int v0, w0, s0, wb0;
  logic [3:0] en_seq [7] = '{4'd12, 4'd13, 4'd2, 4'd6, 4'd0, 4'd15, 4'd14};

  initial begin
    rst = 1'b1;
    set_en(1'b1);
    drive(4'h9);
    tick(2);
    check("rst_cnt_out",    32'(ifa.cnt_out),    0);
    check("rst_cnt_valid",  32'(ifa.cnt_valid),  0);
    check("rst_wrap",       32'(ifa.wrap),       0);
    check("rst_skip_err",   32'(ifa.skip_err),   0);
    check("rst_wrap_count", 32'(ifa.wrap_count), 0);
    check("rst_locked",     32'(ifa.locked),     0);

    // First acceptance lands on the 5th edge after release.
    rst = 1'b0;
    tick(4);
    check("lat_early_valid", 32'(ifa.cnt_valid), 0);
    check("lat_early_lock",  32'(ifa.locked),    0);
    tick(1);
    check("lat_valid",    32'(ifa.cnt_valid), 1);
    check("lat_cnt_out",  32'(ifa.cnt_out),   9);
    check("lat_locked",   32'(ifa.locked),    1);
    check("lat_wrap",     32'(ifa.wrap),      0);
    check("lat_skip_err", 32'(ifa.skip_err),  0);
    tick(1);
    check("lat_pulse_end", 32'(ifa.cnt_valid), 0);
    tick(10);
    check("stable_no_repulse", 32'(ifa.cnt_valid), 0);

    // Full count 0..15,0,1 from a fresh start.
    rst = 1'b1;
    drive(4'h0);
    tick(1);
    rst = 1'b0;
    v0 = vld_a; w0 = wrp_a; s0 = skp_a;
    for (int i = 0; i < 18; i++) begin
      drive(4'(i % 16));
      tick(10);
    end
    check("seq_valid_pulses", 32'(vld_a - v0), 18);
    check("seq_wrap_pulses",  32'(wrp_a - w0), 1);
    check("seq_wrap_on_17th", 32'(wrap_at_a - v0), 17);
    check("seq_skip_pulses",  32'(skp_a - s0), 0);
    check("seq_wrap_count",   32'(ifa.wrap_count), 1);
    check("seq_cnt_out",      32'(ifa.cnt_out), 1);

    // Walk up to 7, then glitches of 8 and 6.
    for (int v = 2; v <= 7; v++) begin
      drive(4'(v));
      tick(10);
    end
    check("pre_glitch_cnt_out", 32'(ifa.cnt_out), 7);
    v0 = vld_a; s0 = skp_a;
    drive(4'd8); tick(2);
    drive(4'd7); tick(10);
    check("glitch8_no_pulse", 32'(vld_a - v0), 0);
    check("glitch8_cnt_out",  32'(ifa.cnt_out), 7);
    drive(4'd6); tick(2);
    drive(4'd8); tick(10);
    check("glitch6_one_pulse", 32'(vld_a - v0), 1);
    check("glitch6_no_skip",   32'(skp_a - s0), 0);
    check("glitch6_cnt_out",   32'(ifa.cnt_out), 8);

    // Skip 3 -> 5.
    rst = 1'b1;
    drive(4'd3);
    tick(1);
    rst = 1'b0;
    tick(10);
    check("skip_start_cnt_out", 32'(ifa.cnt_out), 3);
    drive(4'd5);
    tick(4);
    check("skip_early_valid", 32'(ifa.cnt_valid), 0);
    tick(1);
    check("skip_valid",    32'(ifa.cnt_valid), 1);
    check("skip_cnt_out",  32'(ifa.cnt_out),   5);
    check("skip_err",      32'(ifa.skip_err),  1);
    check("skip_wrap",     32'(ifa.wrap),      0);
    tick(1);
    check("skip_err_end",  32'(ifa.skip_err),  0);

    // Mid-run reset with 11 stable, then re-acquire through INIT.
    drive(4'd11);
    tick(10);
    check("pre_rst_cnt_out", 32'(ifa.cnt_out), 11);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_cnt_out", 32'(ifa.cnt_out), 0);
    check("midrst_locked",  32'(ifa.locked),  0);
    v0 = vld_a; s0 = skp_a;
    tick(10);
    check("reacq_cnt_out", 32'(ifa.cnt_out), 11);
    check("reacq_pulses",  32'(vld_a - v0), 1);
    check("reacq_no_skip", 32'(skp_a - s0), 0);
    check("reacq_locked",  32'(ifa.locked), 1);

    // Enable low while the bus moves: nothing reported.
    v0 = vld_a; s0 = skp_a;
    set_en(1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(en_seq[k]);
      tick(3);
    end
    check("en_low_no_pulse", 32'(vld_a - v0), 0);
    check("en_low_cnt_out",  32'(ifa.cnt_out), 11);
    set_en(1'b1);
    tick(2);
    check("en_rise_early", 32'(ifa.cnt_valid), 0);
    tick(1);
    check("en_rise_valid",   32'(ifa.cnt_valid), 1);
    check("en_rise_cnt_out", 32'(ifa.cnt_out),   14);
    check("en_rise_skip",    32'(ifa.skip_err),  1);

    // Five full laps: the 2-bit tally saturates at 3.
    rst = 1'b1;
    drive(4'd0);
    tick(1);
    rst = 1'b0;
    w0 = wrp_a; wb0 = wrp_b; s0 = skp_a;
    for (int lap = 0; lap < 5; lap++) begin
      for (int v = 0; v < 16; v++) begin
        drive(4'(v));
        tick(10);
      end
    end
    drive(4'd0);
    tick(10);
    check("sat_wrap_pulses_b", 32'(wrp_b - wb0), 5);
    check("sat_wrap_count_b",  32'(ifb.wrap_count), 3);
    check("sat_wrap_pulses_a", 32'(wrp_a - w0), 5);
    check("sat_wrap_count_a",  32'(ifa.wrap_count), 5);
    check("sat_no_skip",       32'(skp_a - s0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
